// File: rtl/decode_uop_queue_pkg.sv
// Shared uop definitions and queue sizing defaults for the decode-to-rename path.
package decode_uop_queue_pkg;

    localparam int LG_UQ_DEPTH  = 3;
    localparam int UQ_AF_THRESH = 6;

    typedef enum logic [2:0] {
        OP_ADDI    = 3'd0,
        OP_LOAD    = 3'd1,
        OP_STORE   = 3'd2,
        OP_BRANCH  = 3'd3,
        OP_RDCYCLE = 3'd4,
        OP_FENCE   = 3'd5,
        OP_CSR     = 3'd6,
        OP_NOP     = 3'd7
    } opcode_t;

    typedef struct packed {
        logic [31:0] pc;
        opcode_t     op;
        logic [4:0]  rd;
        logic        serializing_op;
    } uop_t;

    // Opcodes that must wait for an empty ROB before allocating.
    function automatic logic is_serializing(input opcode_t op);
        return (op == OP_RDCYCLE) || (op == OP_FENCE) || (op == OP_CSR);
    endfunction

endpackage

// File: rtl/decode_uop_queue_uq_ptr.sv
// FIFO pointer with wrap bit: synchronous clear wins over increment.
module uq_ptr #(
    parameter int LG_DEPTH = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              inc,
    output logic [LG_DEPTH:0] ptr
);

    logic [LG_DEPTH:0] ptr_q;
    logic [LG_DEPTH:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/decode_uop_queue.sv
// Elastic uop FIFO between decode and rename/allocate, with serializing-uop
// hold at the head and single-cycle flush.
module decode_uop_queue
    import decode_uop_queue_pkg::*;
#(
    parameter int LG_DEPTH  = LG_UQ_DEPTH,
    parameter int AF_THRESH = UQ_AF_THRESH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     rob_empty,
    input  logic                     in_valid,
    input  logic [$bits(uop_t)-1:0]  in_uop,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [$bits(uop_t)-1:0]  out_uop,
    input  logic                     out_ready,
    output logic [LG_DEPTH:0]        occupancy,
    output logic                     almost_full
);

    localparam int                DEPTH  = 2 ** LG_DEPTH;
    localparam int                UOP_W  = $bits(uop_t);
    localparam logic [LG_DEPTH:0] DEPTH_W = (LG_DEPTH + 1)'(DEPTH);
    localparam logic [LG_DEPTH:0] AF_W    = (LG_DEPTH + 1)'(AF_THRESH);

    logic [UOP_W-1:0]  mem_q [DEPTH];
    logic [LG_DEPTH:0] head_ptr;
    logic [LG_DEPTH:0] tail_ptr;
    logic              clr;
    logic              empty;
    logic              full;
    logic              enq;
    logic              deq;
    uop_t              head_uop;

    assign clr = reset | flush;

    uq_ptr #(.LG_DEPTH(LG_DEPTH)) u_head_ptr (
        .clk (clk),
        .clr (clr),
        .inc (deq),
        .ptr (head_ptr)
    );

    uq_ptr #(.LG_DEPTH(LG_DEPTH)) u_tail_ptr (
        .clk (clk),
        .clr (clr),
        .inc (enq),
        .ptr (tail_ptr)
    );

    assign empty = (head_ptr == tail_ptr);
    assign full  = (head_ptr[LG_DEPTH-1:0] == tail_ptr[LG_DEPTH-1:0]) &&
                   (head_ptr[LG_DEPTH] != tail_ptr[LG_DEPTH]);

    // in_ready ignores out_ready so a full queue never enqueues behind a same-cycle pop.
    assign in_ready = !full && !flush;
    assign enq      = in_valid && in_ready;

    assign out_uop   = mem_q[head_ptr[LG_DEPTH-1:0]];
    assign head_uop  = uop_t'(out_uop);
    assign out_valid = !empty && !(head_uop.serializing_op && !rob_empty);
    assign deq       = out_valid && out_ready;

    assign occupancy   = tail_ptr - head_ptr;
    assign almost_full = (occupancy >= AF_W);

    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[tail_ptr[LG_DEPTH-1:0]] <= in_uop;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(enq && full)) else $error("enqueue while full");
            assert (!(deq && empty)) else $error("dequeue while empty");
            assert (occupancy <= DEPTH_W) else $error("occupancy above depth");
        end
    end
`endif

endmodule

// File: tb/tb_decode_uop_queue.sv
// Scoreboard bench for decode_uop_queue: a queue model predicts handshakes and head order.
module tb_decode_uop_queue;
    import decode_uop_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int AFT   = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       rob_empty;
    logic       in_valid;
    uop_t       in_uop;
    logic       in_ready;
    logic       out_valid;
    uop_t       out_uop;
    logic       out_ready;
    logic [3:0] occupancy;
    logic       almost_full;

    uop_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   n_out      = 0;
    int   n0;

    always #5 clk = ~clk;

    decode_uop_queue dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .rob_empty   (rob_empty),
        .in_valid    (in_valid),
        .in_uop      (in_uop),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_uop     (out_uop),
        .out_ready   (out_ready),
        .occupancy   (occupancy),
        .almost_full (almost_full)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic uop_t mk(input opcode_t op, input logic [31:0] pc);
        uop_t u;
        u.pc             = pc;
        u.op             = op;
        u.rd             = pc[6:2];
        u.serializing_op = is_serializing(op);
        return u;
    endfunction

    // One clock: check outputs against the model at negedge, apply model handshakes, advance.
    task automatic cycle();
        int   cnt;
        logic exp_ir;
        logic exp_ov;
        logic accepted;
        uop_t exp_u;
        accepted = 1'b0;
        @(negedge clk);
        cnt = sb.size();
        if (!reset) begin
            exp_ir = (cnt < DEPTH) && !flush;
            exp_ov = 1'b0;
            if (cnt > 0) exp_ov = !(sb[0].serializing_op && !rob_empty);
            check("occupancy", 64'(occupancy), 64'(cnt));
            check("in_ready", 64'(in_ready), 64'(exp_ir));
            check("out_valid", 64'(out_valid), 64'(exp_ov));
            check("almost_full", 64'(almost_full), 64'(cnt >= AFT));
            if (exp_ov && out_ready) begin
                exp_u = sb.pop_front();
                check("out_uop", 64'(out_uop), 64'(exp_u));
                n_out++;
            end
            if (in_valid && exp_ir) begin
                sb.push_back(in_uop);
                accepted = 1'b1;
            end
        end
        if (reset || flush) sb.delete();
        @(posedge clk);
        #1;
        if (accepted) in_uop.pc = in_uop.pc + 32'd4;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        rob_empty = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_uop    = mk(OP_ADDI, 32'h1000);
        @(posedge clk); #1;
        cycle();
        reset = 1'b0;
        cycle();

        // Fill to full, one refused attempt, then drain in order.
        in_valid = 1'b1;
        repeat (9) cycle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (9) cycle();

        // Continuous streaming.
        in_uop   = mk(OP_LOAD, 32'h2000);
        in_valid = 1'b1;
        n0 = n_out;
        repeat (40) cycle();
        check("stream_count", 64'(n_out - n0), 64'd39);
        in_valid = 1'b0;
        repeat (2) cycle();

        // Full with simultaneous push and pop.
        in_uop    = mk(OP_STORE, 32'h3000);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        repeat (8) cycle();
        out_ready = 1'b1;
        repeat (2) cycle();
        in_valid = 1'b0;
        repeat (9) cycle();

        // Serializing uop held until ROB drains.
        rob_empty = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_uop    = mk(OP_ADDI, 32'h4000);
        cycle();
        in_uop = mk(OP_RDCYCLE, 32'h4004);
        cycle();
        in_uop = mk(OP_ADDI, 32'h4008);
        cycle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n0 = n_out;
        repeat (3) cycle();
        check("ser_held_count", 64'(n_out - n0), 64'd1);
        rob_empty = 1'b1;
        repeat (3) cycle();
        check("ser_release_count", 64'(n_out - n0), 64'd3);

        // Flush mid-stream with a same-cycle enqueue attempt.
        in_uop    = mk(OP_BRANCH, 32'h5000);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (5) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        in_uop = mk(OP_NOP, 32'h6000);
        cycle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) cycle();

        // Reset mid-operation.
        in_uop    = mk(OP_CSR, 32'h7000);
        in_uop.serializing_op = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (7) cycle();
        reset = 1'b1;
        cycle();
        reset    = 1'b0;
        in_valid = 1'b0;
        cycle();
        in_valid = 1'b1;
        in_uop   = mk(OP_ADDI, 32'h8000);
        cycle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n0 = n_out;
        repeat (2) cycle();
        check("post_reset_out", 64'(n_out - n0), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
